// File: rtl/encoder16_4_sync.sv
// Sequential 16-to-4 priority encoder: synchronises and debounces 16 active-low
// request lines, then reports the highest active index through a valid/ack handshake.
module encoder16_4_sync #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_n,
  input  logic        ack,
  output logic [3:0]  code,
  output logic        valid,
  output logic        multi,
  output logic        busy
);

  // Handshake: valid rises on acceptance and holds code/multi steady; the
  // first edge with ack=1 while valid=1 completes the transfer and drops valid.
  // ack is ignored whenever valid=0.

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       state;
  logic [15:0]      sync1;
  logic [15:0]      sync2;
  logic [15:0]      act;
  logic [15:0]      snap;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       enc;
  logic             many;

  function automatic logic [3:0] top_index(input logic [15:0] v);
    top_index = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) top_index = 4'(i);
    end
  endfunction

  assign act  = ~sync2;
  assign enc  = top_index(snap);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign many = |(snap & (snap - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      code  <= 4'h0;
      valid <= 1'b0;
      multi <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sync1 <= req_n;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          if (act != '0) begin
            snap  <= act;
            cnt   <= '0;
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (act != snap) begin
            if (act == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              snap <= act;
              cnt  <= '0;
            end
          end else if (cnt == CNT_MAX) begin
            code  <= enc;
            multi <= many;
            valid <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (ack) begin
            valid <= 1'b0;
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Any active line restarts the quiet period, so a held key cannot re-fire.
          if (act != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder16_4_sync.sv
// Directed bench for encoder16_4_sync with DEB_CYCLES=4: latency, priority,
// bounce rejection, hold/re-trigger, ack-while-idle and mid-operation reset.
module tb_encoder16_4_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_n;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic        multi;
  logic        busy;

  int total = 0;
  int bad   = 0;

  encoder16_4_sync #(.DEB_CYCLES(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_n (req_n),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .multi (multi),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_event(input string tag, input logic [3:0] exp_code, input logic exp_multi);
    chk({tag, "_valid"}, 16'(valid), 16'd1);
    chk({tag, "_code"},  16'(code),  16'(exp_code));
    chk({tag, "_multi"}, 16'(multi), 16'(exp_multi));
    chk({tag, "_busy"},  16'(busy),  16'd1);
  endtask

  // Press given pattern from IDLE: valid must be low after edge 6, high after edge 7.
  task automatic press_expect(input string tag, input logic [15:0] pat,
                              input logic [3:0] exp_code, input logic exp_multi);
    req_n = pat;
    tick(6);
    chk({tag, "_early"}, 16'(valid), 16'd0);
    tick(1);
    chk_event(tag, exp_code, exp_multi);
  endtask

  // One-edge ack, then release all lines; back in IDLE exactly 6 edges after release.
  task automatic ack_release(input string tag);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk({tag, "_ackdrop"}, 16'(valid), 16'd0);
    chk({tag, "_relbusy"}, 16'(busy),  16'd1);
    req_n = 16'hFFFF;
    tick(5);
    chk({tag, "_stillbusy"}, 16'(busy), 16'd1);
    tick(1);
    chk({tag, "_idle"}, 16'(busy), 16'd0);
  endtask

  initial begin
    rst   = 1'b1;
    req_n = 16'hFFFF;
    ack   = 1'b0;

    // 1. Reset then idle
    tick(2);
    rst = 1'b0;
    chk("rst_code",  16'(code),  16'd0);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_multi", 16'(multi), 16'd0);
    chk("rst_busy",  16'(busy),  16'd0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_quiet", {14'd0, valid, busy}, 16'd0);
    end

    // 2. Single press on line 5
    press_expect("line5", 16'hFFDF, 4'h5, 1'b0);
    tick(3);
    chk("line5_holdvalid", 16'(valid), 16'd1);
    ack_release("line5");
    chk("line5_code_kept", 16'(code), 16'h5);

    // 3. Multiple lines, then line 0 alone
    press_expect("l15l0", 16'h7FFE, 4'hF, 1'b1);
    ack_release("l15l0");
    press_expect("line0", 16'hFFFE, 4'h0, 1'b0);
    ack_release("line0");
    press_expect("all16", 16'h0000, 4'hF, 1'b1);
    ack_release("all16");

    // 4. Bounce rejection on line 3
    req_n = 16'hFFF7; tick(2);
    req_n = 16'hFFFF; tick(1);
    req_n = 16'hFFF7; tick(2);
    req_n = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bounce_novalid", 16'(valid), 16'd0);
    end
    chk("bounce_idle", 16'(busy), 16'd0);
    press_expect("line3", 16'hFFF7, 4'h3, 1'b0);
    ack_release("line3");

    // 4b. Glitch to a different pattern restarts debounce on the new one
    req_n = 16'hFFF7;
    tick(4);
    req_n = 16'hFF7F;
    tick(6);
    chk("switch_early", 16'(valid), 16'd0);
    tick(1);
    chk_event("switch", 4'h7, 1'b0);
    ack_release("switch");

    // 5. Line 9 held through ack and 30 more cycles
    req_n = 16'hFDFF;
    tick(7);
    chk_event("line9a", 4'h9, 1'b0);
    ack = 1'b1;
    tick(3);
    ack = 1'b0;
    chk("line9_ackheld", 16'(valid), 16'd0);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk("line9_held", {14'd0, valid, busy}, 16'd1);
    end
    req_n = 16'hFFFF;
    tick(6);
    chk("line9_idle", 16'(busy), 16'd0);
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("ack_in_idle", {14'd0, valid, busy}, 16'd0);
    end
    req_n = 16'hFDFF;
    tick(6);
    chk("ack_in_debounce", {14'd0, valid, busy}, 16'd1);
    ack = 1'b0;
    tick(1);
    chk_event("line9b", 4'h9, 1'b0);
    ack_release("line9b");

    // 6. Reset during DEBOUNCE
    req_n = 16'hFDFF;
    tick(4);
    chk("deb_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstdeb_valid", 16'(valid), 16'd0);
    chk("rstdeb_code",  16'(code),  16'd0);
    chk("rstdeb_busy",  16'(busy),  16'd0);
    tick(6);
    chk("rstdeb_early", 16'(valid), 16'd0);
    tick(1);
    chk_event("rstdeb_fresh", 4'h9, 1'b0);

    // Reset during HOLD with a multi pattern
    req_n = 16'h7FFE;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rsthold_valid", 16'(valid), 16'd0);
    chk("rsthold_code",  16'(code),  16'd0);
    chk("rsthold_busy",  16'(busy),  16'd0);
    tick(6);
    chk("rsthold_early", 16'(valid), 16'd0);
    tick(1);
    chk_event("rsthold_fresh", 4'hF, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rsthold2_valid", 16'(valid), 16'd0);
    chk("rsthold2_multi", 16'(multi), 16'd0);
    chk("rsthold2_busy",  16'(busy),  16'd0);
    tick(7);
    chk_event("rsthold2_fresh", 4'hF, 1'b1);
    ack_release("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
